// File: rtl/hook_grab_controller.sv
// Hook sequencing controller: launch, grab, weighted retract, deposit, scoring and retract timeout.
// Optional feature macro: HOOK_WEIGHT_SLOWDOWN_EN (slows loaded retraction by object weight).
module hook_grab_controller #(
  parameter int unsigned OBJ_ID_W           = 4,
  parameter logic [3:0]  BASE_SPEED         = 4'd4,
  parameter int unsigned MAX_RETRACT_FRAMES = 600
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                enable,
  input  logic                startOfFrame,
  input  logic                fireBtn,
  input  logic                tipHit,
  input  logic [OBJ_ID_W-1:0] hitId,
  input  logic [7:0]          hitValue,
  input  logic [2:0]          hitWeight,
  input  logic                hookAtLimit,
  input  logic                hookHome,
  output logic                sendHook,
  output logic                retract,
  output logic [3:0]          speed,
  output logic                grabbed,
  output logic [OBJ_ID_W-1:0] grabbedId,
  output logic                removeObj,
  output logic                scoreValid,
  output logic [7:0]          scoreAdd,
  output logic [15:0]         totalScore,
  output logic                timeoutErr
);

  localparam logic [2:0] S_IDLE           = 3'd0;
  localparam logic [2:0] S_EXTEND         = 3'd1;
  localparam logic [2:0] S_RETRACT_EMPTY  = 3'd2;
  localparam logic [2:0] S_RETRACT_LOADED = 3'd3;
  localparam logic [2:0] S_DEPOSIT        = 3'd4;

  localparam logic [9:0] LP_MAX_FRAMES = 10'(MAX_RETRACT_FRAMES);

  logic [2:0]          r_state;
  logic                r_fire_prev;
  logic [9:0]          r_frame_cnt;
  logic [7:0]          r_value;
  logic                r_send;
  logic                r_retract;
  logic [3:0]          r_speed;
  logic                r_grabbed;
  logic [OBJ_ID_W-1:0] r_grabbed_id;
  logic                r_remove;
  logic                r_score_valid;
  logic [7:0]          r_score_add;
  logic [15:0]         r_total;
  logic                r_timeout;

  logic [2:0]  w_next;
  logic        w_fire_edge;
  logic        w_in_retract;
  logic        w_next_retract;
  logic        w_timeout;
  logic        w_capture;
  logic [3:0]  w_loaded_speed;
  logic [16:0] w_sum;

  assign w_fire_edge    = fireBtn & ~r_fire_prev;
  assign w_in_retract   = (r_state == S_RETRACT_EMPTY) || (r_state == S_RETRACT_LOADED);
  assign w_next_retract = (w_next == S_RETRACT_EMPTY) || (w_next == S_RETRACT_LOADED);
  assign w_timeout      = enable && w_in_retract && (r_frame_cnt == LP_MAX_FRAMES);
  assign w_capture      = enable && (r_state == S_EXTEND) && tipHit;
  assign w_sum          = {1'b0, r_total} + {9'd0, r_score_add};

`ifdef HOOK_WEIGHT_SLOWDOWN_EN
  assign w_loaded_speed = ({1'b0, hitWeight} >= BASE_SPEED) ? 4'd1 : (BASE_SPEED - {1'b0, hitWeight});
`else
  logic w_unused_weight;
  assign w_unused_weight = ^hitWeight;
  assign w_loaded_speed  = BASE_SPEED;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:           if (w_fire_edge) w_next = S_EXTEND;
      S_EXTEND: begin
        if (tipHit)           w_next = S_RETRACT_LOADED;
        else if (hookAtLimit) w_next = S_RETRACT_EMPTY;
      end
      S_RETRACT_EMPTY:  if (w_timeout || hookHome) w_next = S_IDLE;
      S_RETRACT_LOADED: begin
        if (w_timeout)     w_next = S_IDLE;
        else if (hookHome) w_next = S_DEPOSIT;
      end
      S_DEPOSIT:        w_next = S_IDLE;
      default:          w_next = S_IDLE;
    endcase
    if (!enable) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state       <= S_IDLE;
      r_fire_prev   <= 1'b1;
      r_frame_cnt   <= '0;
      r_value       <= '0;
      r_send        <= 1'b0;
      r_retract     <= 1'b0;
      r_speed       <= BASE_SPEED;
      r_grabbed     <= 1'b0;
      r_grabbed_id  <= '0;
      r_remove      <= 1'b0;
      r_score_valid <= 1'b0;
      r_score_add   <= '0;
      r_total       <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_fire_prev   <= fireBtn;
      r_send        <= (r_state == S_IDLE) && (w_next == S_EXTEND);
      r_retract     <= w_next_retract;
      r_grabbed     <= (w_next == S_RETRACT_LOADED) || (w_next == S_DEPOSIT);
      r_remove      <= (w_next == S_DEPOSIT);
      r_score_valid <= (w_next == S_DEPOSIT);
      r_score_add   <= (w_next == S_DEPOSIT) ? r_value : '0;
      r_timeout     <= w_timeout;

      // Counter only runs while staying inside a retract state, so entry clears it.
      if (w_in_retract && w_next_retract) begin
        if (startOfFrame) r_frame_cnt <= r_frame_cnt + 10'd1;
      end else begin
        r_frame_cnt <= '0;
      end

      if (w_capture) begin
        r_grabbed_id <= hitId;
        r_value      <= hitValue;
        r_speed      <= w_loaded_speed;
      end else if (w_next == S_IDLE) begin
        r_grabbed_id <= '0;
        r_value      <= '0;
        r_speed      <= BASE_SPEED;
      end else if (w_next != S_RETRACT_LOADED) begin
        r_speed      <= BASE_SPEED;
      end

      if (enable && (r_state == S_DEPOSIT))
        r_total <= w_sum[16] ? '1 : w_sum[15:0];
    end
  end

  assign sendHook   = r_send;
  assign retract    = r_retract;
  assign speed      = r_speed;
  assign grabbed    = r_grabbed;
  assign grabbedId  = r_grabbed_id;
  assign removeObj  = r_remove;
  assign scoreValid = r_score_valid;
  assign scoreAdd   = r_score_add;
  assign totalScore = r_total;
  assign timeoutErr = r_timeout;

endmodule

// File: doc/hook_grab_controller.md
# hook_grab_controller

Sequencing controller for the swinging/extending hook datapath in the game-control layer. It turns the player's fire button into a one-cycle hook launch, watches the hook-tip collision and limit/home status, and latches the grabbed object. It sets the retraction speed from object weight and, on return, awards score and issues an object-removal command. It sits between the input debouncer, the hook datapath, the object manager and the score display.

## Interface
- `OBJ_ID_W`, 4: width of object identifier.
- `BASE_SPEED`, 4: extension and empty-retraction speed, px per frame step.
- `MAX_RETRACT_FRAMES`, 600: frames allowed in a retract state before forced abort.
- `clk`  in  1  system clock.
- `resetN`  in  1  reset; one clock, reset is synchronous and active-low.
- `enable`  in  1  game running; low forces IDLE synchronously.
- `startOfFrame`  in  1  one-cycle pulse per video frame.
- `fireBtn`  in  1  debounced fire level.
- `tipHit`  in  1  hook tip overlaps a live object (level).
- `hitId`  in  OBJ_ID_W  id of overlapped object, valid with `tipHit`.
- `hitValue`  in  8  score value of overlapped object.
- `hitWeight`  in  3  weight of overlapped object, 0 = lightest.
- `hookAtLimit`  in  1  hook reached max length or screen edge.
- `hookHome`  in  1  hook back at minimum length.
- `sendHook`  out  1  one-cycle launch pulse to hook datapath.
- `retract`  out  1  level; hook must retract while high.
- `speed`  out  4  current extension/retraction step.
- `grabbed`  out  1  object currently attached.
- `grabbedId`  out  OBJ_ID_W  attached object id.
- `removeObj`  out  1  one-cycle pulse: delete `grabbedId` from field.
- `scoreValid`  out  1  one-cycle pulse: `scoreAdd` is valid.
- `scoreAdd`  out  8  value being awarded.
- `totalScore`  out  16  saturating accumulated score.
- `timeoutErr`  out  1  one-cycle pulse on forced abort.

## Operation
- States: IDLE, EXTEND, RETRACT_EMPTY, RETRACT_LOADED, DEPOSIT.
- IDLE: `fireBtn`=1 with registered previous sample 0 (rising edge) -> EXTEND. Held button does not relaunch.
- EXTEND: `tipHit`=1 -> latch `hitId`/`hitValue`/`hitWeight`, go RETRACT_LOADED. Otherwise `hookAtLimit`=1 -> RETRACT_EMPTY. If both are high in the same cycle, hit wins.
- RETRACT_EMPTY: `hookHome` -> IDLE.
- RETRACT_LOADED: `hookHome` -> DEPOSIT. `tipHit` is ignored.
- DEPOSIT: lasts one cycle, then IDLE.
- `retract` is high in both RETRACT states. `grabbed` is high in RETRACT_LOADED and DEPOSIT.
- `speed`: equals `BASE_SPEED` in IDLE, EXTEND and RETRACT_EMPTY. In RETRACT_LOADED it is `BASE_SPEED - weight`, clamped to a minimum of 1 (4-bit unsigned, no wrap).
- Retract timeout: a 10-bit frame counter clears on entry to either RETRACT state and increments on `startOfFrame`. When it reaches `MAX_RETRACT_FRAMES`:
  - go IDLE and pulse `timeoutErr`;
  - drop the latched object with no score and no `removeObj`.
- `totalScore` += `scoreAdd` in the DEPOSIT cycle, saturating at 16'hFFFF.
- `enable`=0: state -> IDLE, timeout counter and latches clear, all pulse outputs 0. `totalScore` is held (cleared only by reset).

## Timing
- Reset values: state IDLE; `sendHook`, `retract`, `grabbed`, `removeObj`, `scoreValid`, `timeoutErr` = 0; `grabbedId` = 0; `scoreAdd` = 0; `totalScore` = 0; `speed` = `BASE_SPEED`. The edge-detect register resets to 1, so a button held through reset does not fire.
- All outputs are registered.
- `sendHook` is high exactly during the first cycle in EXTEND, one cycle after the edge is sampled.
- `removeObj`, `scoreValid` and `scoreAdd` are valid together for exactly the DEPOSIT cycle. `scoreAdd` returns to 0 afterwards.
- Collision response: `retract`, `grabbed` and the new `speed` are visible one cycle after the `tipHit` sample.
- A fire edge during EXTEND, RETRACT or DEPOSIT is ignored, not queued.
- Reset asserted mid-retract returns to reset values on the next edge.

## Configuration
- `HOOK_WEIGHT_SLOWDOWN_EN` defined: loaded retraction speed is `BASE_SPEED - weight`, clamped to 1.
- Not defined: `speed` is always `BASE_SPEED` and `hitWeight` is unused. All other behaviour is unchanged.

## Test plan
- Reset with `fireBtn`=1, then hold -> no `sendHook`. Release, then press -> `sendHook` one cycle; `retract`=0; `speed`=4.
- EXTEND, `hookAtLimit`=1, then later `hookHome`=1 -> `retract` high through RETRACT_EMPTY; no `scoreValid`; back to IDLE.
- EXTEND, `tipHit` with id=5, value=50, weight=2 -> `grabbed`=1, `grabbedId`=5, `speed`=2 (macro on) or 4 (macro off). On `hookHome`, a one-cycle `removeObj`+`scoreValid` with `scoreAdd`=50; `totalScore`=50.
- `tipHit` and `hookAtLimit` in the same cycle with weight=7 -> RETRACT_LOADED, `speed`=1 (clamped).
- Loaded retract with no `hookHome` for 600 `startOfFrame` pulses -> `timeoutErr` pulse, IDLE, `grabbed`=0, score unchanged.
- `totalScore`=16'hFFF0, deposit value 200 -> `totalScore`=16'hFFFF. Then `enable`=0 mid-EXTEND -> IDLE next cycle and `totalScore` held.
